uart_tx_core: RTL

Transmit half of the board UART, responding to the host's active-low `wrn` write strobe. Each strobe takes one byte into a transmit holding register (THR). The byte moves to a transmit shift register (TSR) and is serialized on `sdo` as start bit, data LSB-first, optional parity, then stop bit(s). `tbre` and `tsre` report buffer state using the same semantics the serial-port wrapper already polls.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_baud_gen.sv | 29 ++
 rtl/uart_tx_core.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the board UART: transmit FSM states, parity modes
// and host access codes used by both the transmit and receive halves.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int PARITY_MODE_EVEN = 0;
  localparam int PARITY_MODE_ODD  = 1;

  // Host strobe levels: the write strobe is active-low, so a low level means write.
  localparam logic MODE_WRITE = 1'b0;
  localparam logic MODE_READ  = 1'b1;

  // Parity over the low data_bits of a byte; odd mode inverts the XOR.
  function automatic logic parity_bit(input logic [7:0] data, input int data_bits,
                                      input int odd);
    logic p;
    p = (odd == PARITY_MODE_ODD);
    for (int i = 0; i < 8; i++) begin
      if (i < data_bits) p = p ^ data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLK_DIV-1 and flags the last cycle of each bit.
// Holding restart high parks the counter at 0 so the next bit starts cleanly.
module uart_baud_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst || restart) begin
      count_reg <= '0;
    end else if (count_reg == LAST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign tick = (count_reg == LAST);

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: host byte into THR, moved to TSR and serialized on sdo as
// start, LSB-first data, optional parity and stop bit(s).
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wrn,
  input  logic [7:0] data_in,
  output logic       tbre,
  output logic       tsre,
  output logic       overrun,
  output logic       sdo
);

  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

  tx_state_t            state_reg;
  logic                 wrn_q;
  logic [7:0]           thr_reg;
  logic [DATA_BITS-1:0] tsr_reg;
  logic                 parity_reg;
  logic [BCW-1:0]       bit_cnt_reg;
  logic                 tbre_reg;
  logic                 tsre_reg;
  logic                 overrun_reg;
  logic                 sdo_reg;

  logic tick;
  logic write_det;
  logic stop_end;
  logic load;

  uart_baud_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(state_reg == IDLE),
    .tick   (tick)
  );

  assign write_det = (wrn == MODE_WRITE) && (wrn_q == MODE_READ);
  assign stop_end  = (state_reg == STOP) && tick && (bit_cnt_reg == LAST_STOP);
  // Transfer decisions use the registered tbre, so a write landing on the
  // same edge as a THR->TSR move still sees a full THR and is rejected.
  assign load      = !tbre_reg && ((state_reg == IDLE) || stop_end);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      wrn_q       <= 1'b1;
      thr_reg     <= '0;
      tsr_reg     <= '0;
      parity_reg  <= 1'b0;
      bit_cnt_reg <= '0;
      tbre_reg    <= 1'b1;
      tsre_reg    <= 1'b1;
      overrun_reg <= 1'b0;
      sdo_reg     <= 1'b1;
    end else begin
      wrn_q       <= wrn;
      overrun_reg <= 1'b0;

      if (write_det) begin
        if (tbre_reg) begin
          thr_reg  <= data_in;
          tbre_reg <= 1'b0;
        end else begin
          overrun_reg <= 1'b1;
        end
      end

      if (load) begin
        tsr_reg    <= thr_reg[DATA_BITS-1:0];
        parity_reg <= parity_bit(thr_reg, DATA_BITS, PARITY_ODD);
        tbre_reg   <= 1'b1;
        tsre_reg   <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          sdo_reg <= 1'b1;
          if (load) begin
            state_reg <= START;
            sdo_reg   <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            state_reg   <= DATA;
            bit_cnt_reg <= '0;
            sdo_reg     <= tsr_reg[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt_reg == LAST_DATA) begin
              bit_cnt_reg <= '0;
              if (PARITY_EN != 0) begin
                state_reg <= PARITY;
                sdo_reg   <= parity_reg;
              end else begin
                state_reg <= STOP;
                sdo_reg   <= 1'b1;
              end
            end else begin
              bit_cnt_reg <= bit_cnt_reg + BCW'(1);
              tsr_reg     <= tsr_reg >> 1;
              sdo_reg     <= tsr_reg[1];
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state_reg   <= STOP;
            bit_cnt_reg <= '0;
            sdo_reg     <= 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            if (bit_cnt_reg == LAST_STOP) begin
              bit_cnt_reg <= '0;
              // A waiting THR byte starts its frame with no idle gap.
              if (load) begin
                state_reg <= START;
                sdo_reg   <= 1'b0;
              end else begin
                state_reg <= IDLE;
                tsre_reg  <= 1'b1;
              end
            end else begin
              bit_cnt_reg <= bit_cnt_reg + BCW'(1);
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          sdo_reg   <= 1'b1;
        end
      endcase
    end
  end

  assign tbre    = tbre_reg;
  assign tsre    = tsre_reg;
  assign overrun = overrun_reg;
  assign sdo     = sdo_reg;

endmodule
